// File: rtl/warp_scheduler_if.sv
// Bundle of launch, instruction-fetch and issue signals for warp_scheduler.
// The master modport is the scheduler side; the slave modport is the environment.
interface warp_scheduler_if #(
  parameter int unsigned NUM_WARPS          = 4,
  parameter int unsigned INSTMEM_ADDR_WIDTH = 16,
  parameter int unsigned INST_LENGTH        = 32
);
  localparam int unsigned WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                          start;
  logic [INSTMEM_ADDR_WIDTH-1:0] start_pc;
  logic [NUM_WARPS-1:0]          warp_enable;
  logic                          inst_req;
  logic [INSTMEM_ADDR_WIDTH-1:0] inst_addr;
  logic                          inst_valid;
  logic [INST_LENGTH-1:0]        inst;
  logic                          issue_valid;
  logic                          issue_ready;
  logic [WID_W-1:0]              issue_warp;
  logic [3:0]                    x;
  logic [3:0]                    y;
  logic [3:0]                    z;
  logic [15:0]                   I;
  logic                          busy;
  logic                          done;

  modport master (
    input  start, start_pc, warp_enable, inst_valid, inst, issue_ready,
    output inst_req, inst_addr, issue_valid, issue_warp, x, y, z, I, busy, done
  );

  modport slave (
    output start, start_pc, warp_enable, inst_valid, inst, issue_ready,
    input  inst_req, inst_addr, issue_valid, issue_warp, x, y, z, I, busy, done
  );
endinterface

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: picks an active warp, fetches its instruction at the warp PC,
// then either issues it to the SP cores or executes HALT/JMP locally.
module warp_scheduler #(
  parameter int unsigned NUM_WARPS          = 4,
  parameter int unsigned INSTMEM_ADDR_WIDTH = 16,
  parameter int unsigned INST_LENGTH        = 32
) (
  input logic               clk,
  input logic               reset,
  warp_scheduler_if.master  bus
);
  localparam int unsigned AW    = INSTMEM_ADDR_WIDTH;
  localparam int unsigned WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam logic [3:0]  OpHalt = 4'hF;
  localparam logic [3:0]  OpJmp  = 4'hE;

  typedef enum logic [1:0] {StIdle, StSelect, StFetch, StIssue} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          pc_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]   active_q;
  logic [WID_W-1:0]       cur_warp_q;
  logic [WID_W-1:0]       last_warp_q;
  logic [INST_LENGTH-1:0] inst_q;
  logic                   done_q;
  logic [WID_W-1:0]       pick;
  logic                   pick_found;
  logic [3:0]             opcode;
  logic                   is_ctrl;

  assign opcode  = inst_q[31:28];
  assign is_ctrl = (opcode == OpHalt) || (opcode == OpJmp);

  // First active warp strictly after last_warp, wrapping modulo NUM_WARPS.
  always_comb begin
    int unsigned      idx;
    logic [WID_W-1:0] cand;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      idx  = (32'(last_warp_q) + i) % NUM_WARPS;
      cand = WID_W'(idx);
      if (!pick_found && active_q[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.start && (bus.warp_enable != '0)) state_d = StSelect;
      StSelect: state_d = pick_found ? StFetch : StIdle;
      StFetch:  if (bus.inst_valid) state_d = StIssue;
      StIssue:  if (is_ctrl || bus.issue_ready) state_d = StSelect;
      default:  state_d = StIdle;
    endcase
  end

  assign bus.inst_req    = (state_q == StFetch);
  assign bus.inst_addr   = (state_q == StFetch) ? pc_q[cur_warp_q] : '0;
  assign bus.issue_valid = (state_q == StIssue) && !is_ctrl;
  assign bus.issue_warp  = bus.issue_valid ? cur_warp_q : '0;
  assign bus.x           = inst_q[27:24];
  assign bus.y           = inst_q[23:20];
  assign bus.z           = inst_q[19:16];
  assign bus.I           = inst_q[15:0];
  assign bus.busy        = (state_q != StIdle);
  // Empty-mask launch is reported a cycle late; the normal end is reported in SELECT itself.
  assign bus.done        = done_q || ((state_q == StSelect) && !pick_found);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      active_q    <= '0;
      cur_warp_q  <= '0;
      last_warp_q <= WID_W'(NUM_WARPS - 1);
      inst_q      <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_WARPS); i++) pc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StIdle) && bus.start && (bus.warp_enable == '0);
      case (state_q)
        StIdle: begin
          if (bus.start && (bus.warp_enable != '0)) begin
            active_q <= bus.warp_enable;
            for (int i = 0; i < int'(NUM_WARPS); i++) pc_q[i] <= bus.start_pc;
          end
        end
        StSelect: if (pick_found) cur_warp_q <= pick;
        StFetch:  if (bus.inst_valid) inst_q <= bus.inst;
        StIssue: begin
          if (state_d == StSelect) begin
            last_warp_q <= cur_warp_q;
            if (opcode == OpHalt) begin
              active_q[cur_warp_q] <= 1'b0;
            end else if (opcode == OpJmp) begin
              pc_q[cur_warp_q] <= AW'(inst_q[15:0]);
            end else begin
              pc_q[cur_warp_q] <= pc_q[cur_warp_q] + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a 4-warp/16-bit-address instance and a
// 1-warp/4-bit-address instance for PC wrap and degenerate round-robin.
module tb_warp_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_WARPS(4), .INSTMEM_ADDR_WIDTH(16), .INST_LENGTH(32)) bus ();
  warp_scheduler_if #(.NUM_WARPS(1), .INSTMEM_ADDR_WIDTH(4),  .INST_LENGTH(32)) sbus ();

  warp_scheduler #(.NUM_WARPS(4), .INSTMEM_ADDR_WIDTH(16), .INST_LENGTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  warp_scheduler #(.NUM_WARPS(1), .INSTMEM_ADDR_WIDTH(4), .INST_LENGTH(32)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a fetch on the 4-warp instance, answers it with zero wait states and leaves
  // the DUT in ISSUE; exp_gap is the number of cycles from the call to inst_req.
  task automatic do_instr(input string tag, input logic [15:0] exp_addr, input logic [31:0] word,
                          input logic exp_issue, input logic [1:0] exp_warp, input int exp_gap);
    int n = 0;
    while (bus.inst_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_req"},  64'(bus.inst_req), 64'd1);
    check({tag, "_gap"},  64'(n), 64'(exp_gap));
    check({tag, "_addr"}, 64'(bus.inst_addr), 64'(exp_addr));
    bus.inst       = word;
    bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    bus.inst       = 32'hDEAD_BEEF;
    check({tag, "_ivalid"}, 64'(bus.issue_valid), 64'(exp_issue));
    if (exp_issue) check({tag, "_iwarp"}, 64'(bus.issue_warp), 64'(exp_warp));
  endtask

  initial begin
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.start_pc     = '0;
    bus.warp_enable  = '0;
    bus.inst_valid   = 1'b0;
    bus.inst         = '0;
    bus.issue_ready  = 1'b1;
    sbus.start       = 1'b0;
    sbus.start_pc    = '0;
    sbus.warp_enable = '0;
    sbus.inst_valid  = 1'b0;
    sbus.inst        = '0;
    sbus.issue_ready = 1'b1;
    tick();
    tick();
    check("reset_outputs", {bus.inst_req, bus.issue_valid, bus.busy, bus.done, bus.inst_addr,
                            bus.issue_warp, bus.x, bus.y, bus.z, bus.I}, 64'd0);
    reset = 1'b1;
    tick();

    // Four warps, always ready: fetch order 0,1,2,3 at 0x10, then warp 0 at 0x11.
    bus.start_pc    = 16'h0010;
    bus.warp_enable = 4'b1111;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rr_busy_select", {bus.busy, bus.inst_req}, 64'b10);
    do_instr("rr_w0", 16'h0010, 32'h1234_5678, 1'b1, 2'd0, 1);
    check("rr_fields", {bus.x, bus.y, bus.z, bus.I}, 64'h2345678);
    do_instr("rr_w1", 16'h0010, 32'h1000_0001, 1'b1, 2'd1, 2);
    do_instr("rr_w2", 16'h0010, 32'h1000_0002, 1'b1, 2'd2, 2);
    do_instr("rr_w3", 16'h0010, 32'h1000_0003, 1'b1, 2'd3, 2);
    do_instr("rr_w0b", 16'h0011, 32'hF000_0000, 1'b0, 2'd0, 2);
    do_instr("rr_h1", 16'h0011, 32'hF000_0000, 1'b0, 2'd0, 2);
    do_instr("rr_h2", 16'h0011, 32'hF000_0000, 1'b0, 2'd0, 2);
    do_instr("rr_h3", 16'h0011, 32'hF000_0000, 1'b0, 2'd0, 2);
    tick();
    check("rr_done", {bus.done, bus.busy}, 64'b11);
    tick();
    check("rr_idle", {bus.done, bus.busy}, 64'b00);

    // Sparse mask, both warps halt immediately.
    bus.start_pc    = 16'h0020;
    bus.warp_enable = 4'b0101;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    do_instr("halt_w0", 16'h0020, 32'hF000_0000, 1'b0, 2'd0, 1);
    do_instr("halt_w2", 16'h0020, 32'hF000_0000, 1'b0, 2'd0, 2);
    tick();
    check("halt_done", {bus.done, bus.busy, bus.inst_req}, 64'b110);
    tick();
    check("halt_done_once", {bus.done, bus.busy}, 64'b00);

    // JMP redirect, then a 5-cycle issue stall with start ignored while busy.
    bus.start_pc    = 16'h0030;
    bus.warp_enable = 4'b0001;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    do_instr("jmp", 16'h0030, 32'hE000_0100, 1'b0, 2'd0, 1);
    bus.issue_ready = 1'b0;
    do_instr("jmp_target", 16'h0100, 32'h1ABC_DEF0, 1'b1, 2'd0, 2);
    bus.start       = 1'b1;
    bus.warp_enable = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_%0d", i),
            {bus.issue_valid, bus.issue_warp, bus.x, bus.y, bus.z, bus.I},
            {33'd0, 1'b1, 2'd0, 4'hA, 4'hB, 4'hC, 16'hDEF0});
      tick();
    end
    bus.start       = 1'b0;
    bus.issue_ready = 1'b1;
    tick();
    do_instr("pc_plus1", 16'h0101, 32'hF000_0000, 1'b0, 2'd0, 1);
    tick();
    check("stall_done", {bus.done, bus.busy}, 64'b11);
    tick();

    // Empty mask: done pulses one cycle later, FSM stays idle.
    bus.warp_enable = 4'b0000;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check("empty_done", {bus.done, bus.busy, bus.inst_req}, 64'b100);
    tick();
    check("empty_done_once", {bus.done, bus.busy}, 64'b00);

    // Reset while fetching; a late inst_valid/issue_ready must be ignored.
    bus.start_pc    = 16'h0040;
    bus.warp_enable = 4'b0001;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("rst_mid_fetch_req", 64'(bus.inst_req), 64'd1);
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    bus.inst       = 32'h1777_7777;
    bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    tick();
    check("rst_mid_fetch_outputs", {bus.inst_req, bus.issue_valid, bus.busy, bus.done,
                                    bus.inst_addr, bus.issue_warp, bus.x, bus.y, bus.z, bus.I},
          64'd0);

    // Single warp, 4-bit PC wraps from 0xF to 0x0.
    sbus.start_pc    = 4'hF;
    sbus.warp_enable = 1'b1;
    sbus.start       = 1'b1;
    tick();
    sbus.start = 1'b0;
    tick();
    check("small_fetch0", {sbus.inst_req, sbus.inst_addr}, {59'd0, 1'b1, 4'hF});
    sbus.inst       = 32'h1000_0000;
    sbus.inst_valid = 1'b1;
    tick();
    sbus.inst_valid = 1'b0;
    check("small_issue", {sbus.issue_valid, sbus.issue_warp}, 64'b10);
    tick();
    tick();
    check("small_wrap", {sbus.inst_req, sbus.inst_addr}, {59'd0, 1'b1, 4'h0});
    sbus.inst       = 32'hF000_0000;
    sbus.inst_valid = 1'b1;
    tick();
    sbus.inst_valid = 1'b0;
    tick();
    check("small_done", {sbus.done, sbus.busy}, 64'b11);
    tick();
    check("small_idle", {sbus.done, sbus.busy}, 64'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
